coeff_carry_resolver: RTL and testbench

COEFF_CARRY_RESOLVER -- requirements
Module: coeff_carry_resolver

---
 rtl/coeff_carry_resolver.sv | 107 ++++++++++
 tb/tb_coeff_carry_resolver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/coeff_carry_resolver.sv
// Serial carry resolver: folds redundant BIT_LEN-wide coefficients into
// WORD_LEN-wide normalized words, one coefficient per cycle, LSB first.
module coeff_carry_lane #(
    parameter int WORD_LEN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [WORD_LEN-1:0] wr_data,
    output logic [WORD_LEN-1:0] word
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     word <= '0;
        else if (wr_en) word <= wr_data;
    end
endmodule

module coeff_carry_resolver #(
    parameter int NUM_ELEMENTS = 8,
    parameter int BIT_LEN      = 58,
    parameter int WORD_LEN     = 16,
    parameter int CARRY_LEN    = BIT_LEN - WORD_LEN + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_LEN-1:0]   terms [NUM_ELEMENTS],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_LEN-1:0]  words [NUM_ELEMENTS],
    output logic [CARRY_LEN-1:0] carry_out
);
    localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [CARRY_LEN-1:0] carry;
    logic [BIT_LEN-1:0]   term_reg [NUM_ELEMENTS];
    logic [BIT_LEN:0]     sum;
    logic [CARRY_LEN-1:0] carry_next;
    logic                 accept;
    logic                 last;

    assign accept     = in_valid && in_ready;
    assign last       = (idx == IDX_W'(NUM_ELEMENTS - 1));
    // carry is bounded below 2^(CARRY_LEN), so sum never exceeds BIT_LEN+1 bits
    assign sum        = {1'b0, term_reg[idx]} + {{WORD_LEN{1'b0}}, carry};
    assign carry_next = sum[BIT_LEN:WORD_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) term_reg[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) term_reg[i] <= terms[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= '0;
            carry_out <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state    <= RUN;
                    idx      <= '0;
                    carry    <= '0;
                    in_ready <= 1'b0;
                end
                RUN: begin
                    carry <= carry_next;
                    if (last) begin
                        carry_out <= carry_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // one word register per element, written on its RUN slot
    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
        coeff_carry_lane #(.WORD_LEN(WORD_LEN)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   ((state == RUN) && (idx == IDX_W'(i))),
            .wr_data (sum[WORD_LEN-1:0]),
            .word    (words[i])
        );
    end
endmodule

// File: tb/tb_coeff_carry_resolver.sv
// Directed + random self-checking bench for coeff_carry_resolver against a
// wide-integer reference of the weighted coefficient sum.
module tb_coeff_carry_resolver;
    localparam int NE = 8, BL = 58, WL = 16, CL = BL - WL + 1;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [BL-1:0] terms [NE];
    logic [WL-1:0] words [NE];
    logic [CL-1:0] carry_out;

    logic [BL-1:0] tv [NE];
    logic [WL-1:0] ew [NE];
    logic [CL-1:0] ec;
    int checks = 0, failures = 0, n_ops = 0, mon_acc = 0, mon_hs = 0;

    always #5 clk = ~clk;

    coeff_carry_resolver dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .terms(terms), .out_valid(out_valid), .out_ready(out_ready),
        .words(words), .carry_out(carry_out)
    );

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready)   mon_acc++;
        if (rst_n && out_valid && out_ready) mon_hs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: full-width weighted sum, then slice into words and carry.
    task automatic model();
        logic [191:0] acc;
        acc = '0;
        for (int i = 0; i < NE; i++) acc += 192'(tv[i]) << (WL * i);
        for (int i = 0; i < NE; i++) ew[i] = acc[WL*i +: WL];
        ec = acc[WL*NE +: CL];
    endtask

    task automatic chk_result();
        for (int i = 0; i < NE; i++) chk($sformatf("word%0d", i), 64'(words[i]), 64'(ew[i]));
        chk("carry_out", 64'(carry_out), 64'(ec));
    endtask

    task automatic start_op(input bit rdy0);
        int n;
        model();
        @(posedge clk); #1;
        for (int i = 0; i < NE; i++) terms[i] = tv[i];
        in_valid  = 1'b1;
        out_ready = rdy0;
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        n_ops++;
    endtask

    task automatic op(input int stall, input bit hold);
        int n;
        start_op(stall == 0);
        if (!hold) in_valid = 1'b0;
        // scramble inputs: they must not be sampled after accept
        for (int i = 0; i < NE; i++) terms[i] = BL'({$urandom, $urandom});
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), 64'd8);
        chk("in_ready_done", 64'(in_ready), 64'd0);
        chk_result();
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk_result();
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < NE; i++) terms[i] = '0;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_carry", 64'(carry_out), 64'd0);
        chk("rst_word0", 64'(words[0]), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // all zeros, out_ready held high
        for (int i = 0; i < NE; i++) tv[i] = '0;
        op(0, 1'b0);
        for (int i = 0; i < NE; i++) chk("zero_word", 64'(words[i]), 64'd0);
        chk("zero_carry", 64'(carry_out), 64'd0);

        // full ripple: 0x1FFFF + 0xFFFF... carries all the way to carry_out
        tv[0] = 58'h1FFFF;
        for (int i = 1; i < NE; i++) tv[i] = 58'hFFFF;
        op(1, 1'b0);
        chk("ripple_w0", 64'(words[0]), 64'hFFFF);
        for (int i = 1; i < NE; i++) chk("ripple_wn", 64'(words[i]), 64'd0);
        chk("ripple_carry", 64'(carry_out), 64'd1);

        // small hand vector: 0x12345 + 0xFFFF<<16 -> 2345, 0000, 0001
        for (int i = 0; i < NE; i++) tv[i] = '0;
        tv[0] = 58'h12345; tv[1] = 58'hFFFF;
        op(0, 1'b0);
        chk("hand_w0", 64'(words[0]), 64'h2345);
        chk("hand_w1", 64'(words[1]), 64'h0000);
        chk("hand_w2", 64'(words[2]), 64'h0001);

        // all ones at full width
        for (int i = 0; i < NE; i++) tv[i] = {BL{1'b1}};
        op(2, 1'b0);
        chk("max_carry_nz", 64'(carry_out != '0), 64'd1);

        // long stall with in_valid held high through DONE
        for (int i = 0; i < NE; i++) tv[i] = BL'(64'h0123_4567_89AB_CDEF * (i + 1));
        op(5, 1'b1);

        // reset mid-operation at RUN index 3
        for (int i = 0; i < NE; i++) tv[i] = 58'h3_0000_0000_AAAA;
        start_op(1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_word0", 64'(words[0]), 64'd0);
        chk("abort_carry", 64'(carry_out), 64'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 64'(out_valid), 64'd0);
        end
        for (int i = 0; i < NE; i++) tv[i] = BL'(58'h2_DEAD_BEEF_0000 + i);
        op(0, 1'b0);

        // back-to-back random operands with random stalls
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NE; i++) tv[i] = BL'({$urandom, $urandom});
            op(int'($urandom_range(0, 3)), 1'b0);
        end

        chk("accept_count", 64'(mon_acc), 64'(n_ops));
        chk("handshake_count", 64'(mon_hs), 64'(n_ops - 1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
